mult_div_unit: RTL and testbench

MULT_DIV_UNIT -- requirements
Module: mult_div_unit

---
 rtl/mult_div_unit.sv | 177 +++++++++++++++++
 tb/tb_mult_div_unit.sv | 344 ++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/mult_div_unit.sv
// Iterative multiply/divide unit with HI/LO result registers.
// Radix-2 shift-add multiply and restoring divide on operand magnitudes, sign fixed up at the end.
module mult_div_unit #(
    parameter int unsigned WIDTH = 32
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             start,
    input  logic [1:0]       op,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             cancel,
    input  logic             wr_hi,
    input  logic             wr_lo,
    input  logic [WIDTH-1:0] wdata,
    output logic             busy,
    output logic             done,
    output logic             dbz,
    output logic [WIDTH-1:0] hi,
    output logic [WIDTH-1:0] lo
);

    localparam int unsigned        CntW     = $clog2(WIDTH + 1);
    localparam logic [CntW-1:0]    LastIter = CntW'(WIDTH - 1);
    localparam logic [WIDTH-1:0]   OneW     = {{(WIDTH - 1){1'b0}}, 1'b1};
    localparam logic [2*WIDTH-1:0] OneP     = {{(2 * WIDTH - 1){1'b0}}, 1'b1};

    typedef enum logic [1:0] {StIdle, StRun, StFix, StDone} state_e;

    state_e             state_q, state_d;
    logic [CntW-1:0]    cnt_q, cnt_d;
    logic               is_div_q, is_div_d;
    logic               neg_res_q, neg_res_d;
    logic               neg_rem_q, neg_rem_d;
    logic [WIDTH:0]     acc_q, acc_d;
    logic [WIDTH-1:0]   q_q, q_d;
    logic [WIDTH-1:0]   m_q, m_d;
    logic [WIDTH-1:0]   hi_q, hi_d;
    logic [WIDTH-1:0]   lo_q, lo_d;
    logic               dbz_q, dbz_d;

    logic               accept;
    logic               sign_a, sign_b;
    logic [WIDTH-1:0]   mag_a, mag_b;
    logic [WIDTH:0]     mul_sum;
    logic [WIDTH:0]     div_shift;
    logic               div_ge;
    logic [WIDTH:0]     div_diff;
    logic [2*WIDTH-1:0] prod, prod_fix;
    logic [WIDTH-1:0]   quot_fix, rem_fix;

    assign busy = (state_q == StRun) || (state_q == StFix);
    assign done = (state_q == StDone);
    assign dbz  = dbz_q;
    assign hi   = hi_q;
    assign lo   = lo_q;

    assign accept = start && !cancel && ((state_q == StIdle) || (state_q == StDone));

    // Unsigned ops (op[0]=1) treat operands as magnitudes directly.
    assign sign_a = !op[0] && a[WIDTH-1];
    assign sign_b = !op[0] && b[WIDTH-1];
    assign mag_a  = sign_a ? (~a + OneW) : a;
    assign mag_b  = sign_b ? (~b + OneW) : b;

    // Multiply step: conditionally add multiplicand, then shift {acc, q} right one place.
    assign mul_sum = acc_q + (q_q[0] ? {1'b0, m_q} : {(WIDTH + 1){1'b0}});

    // Divide step: shift next dividend bit into the partial remainder, subtract if it fits.
    assign div_shift = {acc_q[WIDTH-1:0], q_q[WIDTH-1]};
    assign div_ge    = (div_shift >= {1'b0, m_q});
    assign div_diff  = div_shift - {1'b0, m_q};

    assign prod     = {acc_q[WIDTH-1:0], q_q};
    assign prod_fix = neg_res_q ? (~prod + OneP) : prod;
    assign quot_fix = neg_res_q ? (~q_q + OneW) : q_q;
    assign rem_fix  = neg_rem_q ? (~acc_q[WIDTH-1:0] + OneW) : acc_q[WIDTH-1:0];

    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        is_div_d  = is_div_q;
        neg_res_d = neg_res_q;
        neg_rem_d = neg_rem_q;
        acc_d     = acc_q;
        q_d       = q_q;
        m_d       = m_q;
        hi_d      = hi_q;
        lo_d      = lo_q;
        dbz_d     = dbz_q;

        if (!busy && !accept) begin
            if (wr_hi) hi_d = wdata;
            if (wr_lo) lo_d = wdata;
        end

        if (cancel) begin
            state_d = StIdle;
        end else begin
            unique case (state_q)
                StIdle, StDone: begin
                    if (start) begin
                        is_div_d  = op[1];
                        neg_res_d = sign_a ^ sign_b;
                        neg_rem_d = sign_a;
                        if (op[1] && (b == '0)) begin
                            hi_d    = a;
                            lo_d    = '1;
                            dbz_d   = 1'b1;
                            state_d = StDone;
                        end else begin
                            acc_d   = '0;
                            q_d     = op[1] ? mag_a : mag_b;
                            m_d     = op[1] ? mag_b : mag_a;
                            cnt_d   = '0;
                            dbz_d   = 1'b0;
                            state_d = StRun;
                        end
                    end else if (state_q == StDone) begin
                        state_d = StIdle;
                    end
                end
                StRun: begin
                    if (is_div_q) begin
                        acc_d = div_ge ? div_diff : div_shift;
                        q_d   = {q_q[WIDTH-2:0], div_ge};
                    end else begin
                        acc_d = {1'b0, mul_sum[WIDTH:1]};
                        q_d   = {mul_sum[0], q_q[WIDTH-1:1]};
                    end
                    cnt_d = cnt_q + 1'b1;
                    if (cnt_q == LastIter) state_d = StFix;
                end
                StFix: begin
                    if (is_div_q) begin
                        hi_d = rem_fix;
                        lo_d = quot_fix;
                    end else begin
                        hi_d = prod_fix[2*WIDTH-1:WIDTH];
                        lo_d = prod_fix[WIDTH-1:0];
                    end
                    state_d = StDone;
                end
                default: state_d = StIdle;
            endcase
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q   <= StIdle;
            cnt_q     <= '0;
            is_div_q  <= 1'b0;
            neg_res_q <= 1'b0;
            neg_rem_q <= 1'b0;
            acc_q     <= '0;
            q_q       <= '0;
            m_q       <= '0;
            hi_q      <= '0;
            lo_q      <= '0;
            dbz_q     <= 1'b0;
        end else begin
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            is_div_q  <= is_div_d;
            neg_res_q <= neg_res_d;
            neg_rem_q <= neg_rem_d;
            acc_q     <= acc_d;
            q_q       <= q_d;
            m_q       <= m_d;
            hi_q      <= hi_d;
            lo_q      <= lo_d;
            dbz_q     <= dbz_d;
        end
    end

endmodule

// File: tb/tb_mult_div_unit.sv
// Self-checking bench for mult_div_unit: 32-bit instance against a 64-bit arithmetic model,
// plus an 8-bit instance for the narrow-width and mid-operation reset cases.
module tb_mult_div_unit;

    logic        clk = 1'b0;
    logic        reset, start, cancel, wr_hi, wr_lo;
    logic [1:0]  op;
    logic [31:0] a, b, wdata;
    logic        busy, done, dbz;
    logic [31:0] hi, lo;

    logic        reset8, start8;
    logic [1:0]  op8;
    logic [7:0]  a8, b8;
    logic        busy8, done8, dbz8;
    logic [7:0]  hi8, lo8;

    int          n_tests = 0;
    int          n_fail  = 0;
    logic [31:0] exp_hi, exp_lo;
    logic        exp_dbz;

    always #5 clk = ~clk;

    mult_div_unit #(.WIDTH(32)) u_dut (
        .clk(clk), .reset(reset), .start(start), .op(op), .a(a), .b(b), .cancel(cancel),
        .wr_hi(wr_hi), .wr_lo(wr_lo), .wdata(wdata),
        .busy(busy), .done(done), .dbz(dbz), .hi(hi), .lo(lo)
    );

    mult_div_unit #(.WIDTH(8)) u_dut8 (
        .clk(clk), .reset(reset8), .start(start8), .op(op8), .a(a8), .b(b8), .cancel(1'b0),
        .wr_hi(1'b0), .wr_lo(1'b0), .wdata(8'h00),
        .busy(busy8), .done(done8), .dbz(dbz8), .hi(hi8), .lo(lo8)
    );

    // Reference {hi, lo} from plain 64-bit arithmetic.
    function automatic logic [63:0] ref_result(input logic [1:0] o, input logic [31:0] x,
                                               input logic [31:0] y);
        longint      sx, sy, sq, sr;
        logic [63:0] ux, uy, p;
        sx = longint'($signed(x));
        sy = longint'($signed(y));
        ux = {32'd0, x};
        uy = {32'd0, y};
        p  = '0;
        case (o)
            2'd0: p = 64'(sx * sy);
            2'd1: p = ux * uy;
            2'd2: begin
                if (y == 32'd0) p = {x, 32'hFFFF_FFFF};
                else begin
                    sq = sx / sy;
                    sr = sx % sy;
                    p  = {sr[31:0], sq[31:0]};
                end
            end
            default: begin
                if (y == 32'd0) p = {x, 32'hFFFF_FFFF};
                else p = {32'(ux % uy), 32'(ux / uy)};
            end
        endcase
        return p;
    endfunction

    // Called and returns at a falling edge; leaves the DUT in its done cycle.
    task automatic do_op(input logic [1:0] o, input logic [31:0] x, input logic [31:0] y,
                         input logic wl, input string name);
        logic [63:0] r;
        int          lat, k;
        bit          busy_bad;
        r       = ref_result(o, x, y);
        exp_dbz = o[1] && (y == 32'd0);
        lat     = exp_dbz ? 0 : 33;
        start = 1'b1; op = o; a = x; b = y; wr_lo = wl; wdata = 32'hDEAD_BEEF;
        @(negedge clk);
        start = 1'b0; wr_lo = 1'b0;
        k = 0; busy_bad = 0;
        while (done !== 1'b1 && k < 60) begin
            if (busy !== 1'b1) busy_bad = 1;
            @(negedge clk);
            k++;
        end
        exp_hi = r[63:32];
        exp_lo = r[31:0];
        n_tests++;
        if (k != lat) begin
            n_fail++;
            $display("FAIL %s latency: got %0d cycles, want %0d", name, k, lat);
        end
        n_tests++;
        if (busy_bad || busy !== 1'b0) begin
            n_fail++;
            $display("FAIL %s busy window: busy_bad=%0d busy_at_done=%b, want 0/0", name,
                     busy_bad, busy);
        end
        n_tests++;
        if (hi !== exp_hi) begin
            n_fail++;
            $display("FAIL %s hi: got %h, want %h", name, hi, exp_hi);
        end
        n_tests++;
        if (lo !== exp_lo) begin
            n_fail++;
            $display("FAIL %s lo: got %h, want %h", name, lo, exp_lo);
        end
        n_tests++;
        if (dbz !== exp_dbz) begin
            n_fail++;
            $display("FAIL %s dbz: got %b, want %b", name, dbz, exp_dbz);
        end
    endtask

    task automatic test_reset();
        reset = 1'b1; reset8 = 1'b1;
        start = 0; cancel = 0; wr_hi = 0; wr_lo = 0; op = 0; a = 0; b = 0; wdata = 0;
        start8 = 0; op8 = 0; a8 = 0; b8 = 0;
        #2;
        reset = 1'b0; reset8 = 1'b0;
        #1;
        n_tests++;
        if ({busy, done, dbz, hi, lo} !== 67'd0 || {busy8, done8, dbz8, hi8, lo8} !== 19'd0) begin
            n_fail++;
            $display("FAIL reset_async: got %b%b%b %h %h / %h %h, want all zero",
                     busy, done, dbz, hi, lo, hi8, lo8);
        end
        repeat (2) @(negedge clk);
        reset = 1'b1; reset8 = 1'b1;
        @(negedge clk);
        n_tests++;
        if ({busy, done, dbz, hi, lo} !== 67'd0) begin
            n_fail++;
            $display("FAIL reset_release: got %b%b%b %h %h, want all zero", busy, done, dbz, hi,
                     lo);
        end
        exp_hi = '0; exp_lo = '0; exp_dbz = 1'b0;
    endtask

    task automatic test_directed();
        do_op(2'd0, 32'hFFFF_FFFD, 32'd7, 1'b0, "mult_neg");
        @(negedge clk);
        do_op(2'd1, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 1'b0, "multu_max");
        do_op(2'd3, 32'd100, 32'd7, 1'b0, "divu_b2b");
        @(negedge clk);
        do_op(2'd2, 32'hFFFF_FFF9, 32'd2, 1'b0, "div_neg");
        @(negedge clk);
        do_op(2'd2, 32'h8000_0000, 32'hFFFF_FFFF, 1'b0, "div_ovf");
        @(negedge clk);
        do_op(2'd3, 32'd5, 32'd0, 1'b0, "divu_zero");
        do_op(2'd1, 32'd3, 32'd4, 1'b0, "multu_after_dbz");
        @(negedge clk);
        do_op(2'd2, 32'h8000_0000, 32'd0, 1'b0, "div_zero");
        do_op(2'd3, 32'd100, 32'd7, 1'b1, "divu_with_wr");
        @(negedge clk);
    endtask

    task automatic test_random();
        logic [1:0]  o;
        logic [31:0] x, y;
        for (int i = 0; i < 40; i++) begin
            o = 2'($urandom_range(0, 3));
            x = $urandom;
            case ($urandom_range(0, 7))
                0:       y = 32'd0;
                1:       y = 32'($urandom_range(1, 15));
                2:       y = 32'hFFFF_FFFF;
                default: y = $urandom;
            endcase
            if ($urandom_range(0, 9) == 0) x = 32'h8000_0000;
            do_op(o, x, y, 1'(($urandom_range(0, 3) == 0)), "random");
            if ($urandom_range(0, 1) == 1) @(negedge clk);
        end
        @(negedge clk);
    endtask

    task automatic test_run_ignores();
        logic [63:0] r;
        int          k;
        r = ref_result(2'd0, 32'h1234_5678, 32'hFEDC_BA98);
        start = 1'b1; op = 2'd0; a = 32'h1234_5678; b = 32'hFEDC_BA98;
        @(negedge clk);
        start = 1'b0;
        repeat (4) @(negedge clk);
        start = 1'b1; op = 2'd3; a = 32'h0000_0077; b = 32'd0;
        wr_lo = 1'b1; wr_hi = 1'b1; wdata = 32'hA5A5_A5A5;
        @(negedge clk);
        start = 1'b0; wr_lo = 1'b0; wr_hi = 1'b0;
        k = 5;
        while (done !== 1'b1 && k < 60) begin
            @(negedge clk);
            k++;
        end
        exp_hi = r[63:32]; exp_lo = r[31:0]; exp_dbz = 1'b0;
        n_tests++;
        if (k != 33) begin
            n_fail++;
            $display("FAIL run_ignore latency: got %0d, want 33", k);
        end
        n_tests++;
        if (hi !== exp_hi || lo !== exp_lo || dbz !== 1'b0) begin
            n_fail++;
            $display("FAIL run_ignore result: got %h_%h dbz=%b, want %h_%h dbz=0", hi, lo, dbz,
                     exp_hi, exp_lo);
        end
        @(negedge clk);
    endtask

    task automatic test_cancel();
        logic [31:0] h0, l0, w;
        logic        d0;
        int          bad;
        h0 = exp_hi; l0 = exp_lo; d0 = exp_dbz;
        start = 1'b1; op = 2'd0; a = $urandom; b = $urandom;
        @(negedge clk);
        start = 1'b0;
        repeat (9) @(negedge clk);
        cancel = 1'b1; start = 1'b1; op = 2'd1; a = 32'd5; b = 32'd6;
        @(negedge clk);
        cancel = 1'b0; start = 1'b0;
        n_tests++;
        if (busy !== 1'b0 || done !== 1'b0) begin
            n_fail++;
            $display("FAIL cancel_idle: got busy=%b done=%b, want 0/0", busy, done);
        end
        bad = 0;
        repeat (40) begin
            @(negedge clk);
            if (done !== 1'b0 || busy !== 1'b0) bad++;
        end
        n_tests++;
        if (bad != 0) begin
            n_fail++;
            $display("FAIL cancel_quiet: got %0d active cycles, want 0", bad);
        end
        n_tests++;
        if (hi !== h0 || lo !== l0 || dbz !== d0) begin
            n_fail++;
            $display("FAIL cancel_hold: got %h %h %b, want %h %h %b", hi, lo, dbz, h0, l0, d0);
        end
        cancel = 1'b1; start = 1'b1; op = 2'd0; a = 32'd1; b = 32'd1;
        @(negedge clk);
        cancel = 1'b0; start = 1'b0;
        @(negedge clk);
        n_tests++;
        if (busy !== 1'b0 || done !== 1'b0) begin
            n_fail++;
            $display("FAIL cancel_start_idle: got busy=%b done=%b, want 0/0", busy, done);
        end
        wr_lo = 1'b1; wdata = 32'h0000_1234;
        @(negedge clk);
        wr_lo = 1'b0;
        exp_lo = 32'h0000_1234;
        n_tests++;
        if (lo !== exp_lo || hi !== h0) begin
            n_fail++;
            $display("FAIL wr_lo: got hi=%h lo=%h, want hi=%h lo=%h", hi, lo, h0, exp_lo);
        end
        w = $urandom;
        wr_hi = 1'b1; wdata = w;
        @(negedge clk);
        wr_hi = 1'b0;
        exp_hi = w;
        n_tests++;
        if (hi !== exp_hi || lo !== exp_lo || dbz !== d0) begin
            n_fail++;
            $display("FAIL wr_hi: got %h %h %b, want %h %h %b", hi, lo, dbz, exp_hi, exp_lo, d0);
        end
    endtask

    task automatic test_width8();
        int k, bad;
        start8 = 1'b1; op8 = 2'd0; a8 = 8'h80; b8 = 8'h80;
        @(negedge clk);
        start8 = 1'b0;
        k = 0;
        while (done8 !== 1'b1 && k < 30) begin
            @(negedge clk);
            k++;
        end
        n_tests++;
        if (k != 9 || hi8 !== 8'h40 || lo8 !== 8'h00) begin
            n_fail++;
            $display("FAIL w8_mult: got lat=%0d %h_%h, want lat=9 40_00", k, hi8, lo8);
        end
        @(negedge clk);
        start8 = 1'b1; op8 = 2'd1; a8 = 8'h0F; b8 = 8'h0F;
        @(negedge clk);
        start8 = 1'b0;
        repeat (3) @(negedge clk);
        reset8 = 1'b0;
        #1;
        n_tests++;
        if ({busy8, done8, dbz8, hi8, lo8} !== 19'd0) begin
            n_fail++;
            $display("FAIL w8_reset: got %b%b%b %h %h, want all zero", busy8, done8, dbz8, hi8,
                     lo8);
        end
        @(negedge clk);
        reset8 = 1'b1;
        bad = 0;
        repeat (20) begin
            @(negedge clk);
            if (done8 !== 1'b0 || busy8 !== 1'b0) bad++;
        end
        n_tests++;
        if (bad != 0 || hi8 !== 8'h00 || lo8 !== 8'h00) begin
            n_fail++;
            $display("FAIL w8_after_reset: got %0d active, %h_%h, want 0, 00_00", bad, hi8, lo8);
        end
        start8 = 1'b1; op8 = 2'd1; a8 = 8'hFF; b8 = 8'hFF;
        @(negedge clk);
        start8 = 1'b0;
        k = 0;
        while (done8 !== 1'b1 && k < 30) begin
            @(negedge clk);
            k++;
        end
        n_tests++;
        if (k != 9 || hi8 !== 8'hFE || lo8 !== 8'h01 || dbz8 !== 1'b0) begin
            n_fail++;
            $display("FAIL w8_multu: got lat=%0d %h_%h dbz=%b, want lat=9 FE_01 dbz=0", k, hi8,
                     lo8, dbz8);
        end
        @(negedge clk);
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        test_reset();
        test_directed();
        test_run_ignores();
        test_cancel();
        test_random();
        test_width8();
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
